four_and_checker: RTL and testbench

FOUR_AND_CHECKER -- requirements
Module: four_and_checker

---
 rtl/four_and_checker.sv | 165 ++++++++++++++++
 tb/tb_four_and_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/four_and_checker.sv
// four_and_checker: scores a 4-input AND gate under test against the ideal
// function. It tracks mismatches, the first failing vector and vector coverage
// over a run that ends on full coverage or when the sample budget is spent.
// Optional watchdog: define FOUR_AND_CHK_TIMEOUT_EN to end a run after
// TIMEOUT_CYCLES consecutive cycles without a sample.
module four_and_checker #(
   parameter int MAX_SAMPLES    = 64,
   parameter int TIMEOUT_CYCLES = 200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        sample_valid,
   input  logic        inA,
   input  logic        inB,
   input  logic        inC,
   input  logic        inD,
   input  logic        dutOut,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [4:0]  errCount,
   output logic [15:0] covered,
   output logic [3:0]  firstErrVec,
   output logic        firstErrValid,
   output logic        timeout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   localparam logic [7:0]  SAMPLE_LIMIT = 8'(MAX_SAMPLES);
   localparam logic [15:0] ALL_COVERED  = 16'hFFFF;

   // Out-of-range parameters are rejected at elaboration.
   if (MAX_SAMPLES < 16 || MAX_SAMPLES > 255 || TIMEOUT_CYCLES < 1) begin : gParamCheck
      $error("four_and_checker: MAX_SAMPLES must be 16..255 and TIMEOUT_CYCLES >= 1");
   end

   // Error count holds at 31 instead of wrapping.
   function automatic logic [4:0] satInc(input logic [4:0] value);
      return (value == 5'd31) ? value : value + 5'd1;
   endfunction

   stateT       state;
   stateT       stateNext;
   logic [7:0]  sampleCount;
   logic [3:0]  vec;
   logic        expected;
   logic        mismatch;
   logic        takeSample;
   logic        startRun;
   logic        lastSample;
   logic        timeoutHit;
   logic [15:0] coveredNext;
   logic [7:0]  sampleCountNext;
   logic [4:0]  errCountNext;

   assign vec  = {inA, inB, inC, inD};
   assign busy = (state == RUN);
   assign done = (state == DONE);

   // Next-value view of the current sample; lastSample folds the sample being
   // registered into the end-of-run decision so nothing is lost at the edge.
   always_comb begin
      expected        = &vec;
      mismatch        = (dutOut != expected);
      takeSample      = (state == RUN) && sample_valid;
      startRun        = start && (state != RUN);
      coveredNext     = covered | (16'd1 << vec);
      sampleCountNext = sampleCount + 8'd1;
      errCountNext    = mismatch ? satInc(errCount) : errCount;
      lastSample      = takeSample &&
                        ((coveredNext == ALL_COVERED) || (sampleCountNext == SAMPLE_LIMIT));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic; start while running is deliberately ignored.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start) stateNext = RUN;
         RUN:     if (lastSample || timeoutHit) stateNext = DONE;
         DONE:    if (start) stateNext = RUN;
         default: stateNext = IDLE;
      endcase
   end

   // Result registers: cleared on run entry, updated per sample in RUN, frozen otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         errCount      <= '0;
         covered       <= '0;
         firstErrVec   <= '0;
         firstErrValid <= 1'b0;
         pass          <= 1'b0;
         sampleCount   <= '0;
      end else if (startRun) begin
         errCount      <= '0;
         covered       <= '0;
         firstErrVec   <= '0;
         firstErrValid <= 1'b0;
         pass          <= 1'b0;
         sampleCount   <= '0;
      end else if (takeSample) begin
         errCount    <= errCountNext;
         covered     <= coveredNext;
         sampleCount <= sampleCountNext;
         if (mismatch && !firstErrValid) begin
            firstErrVec   <= vec;
            firstErrValid <= 1'b1;
         end
         if (lastSample) begin
            pass <= (errCountNext == 5'd0) && (coveredNext == ALL_COVERED);
         end
      end
   end

`ifdef FOUR_AND_CHK_TIMEOUT_EN
   localparam int                IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

   logic [IDLE_W-1:0] idleCount;

   // Fires on the edge where the idle count would reach the limit; pass stays 0
   // because it is only written when a final sample is registered.
   assign timeoutHit = (state == RUN) && !sample_valid &&
                       ((idleCount + IDLE_W'(1)) == IDLE_LIMIT);

   // Watchdog: counts RUN cycles since the last sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idleCount <= '0;
         timeout   <= 1'b0;
      end else if (startRun) begin
         idleCount <= '0;
         timeout   <= 1'b0;
      end else if (state == RUN) begin
         if (sample_valid) begin
            idleCount <= '0;
         end else begin
            idleCount <= idleCount + IDLE_W'(1);
            if (timeoutHit) begin
               timeout <= 1'b1;
            end
         end
      end
   end
`else
   assign timeoutHit = 1'b0;
   assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_four_and_checker.sv
// Scoreboard bench for four_and_checker: stimulus pushes the expected end-of-run
// result; a monitor pops and compares it whenever done rises.
module tb_four_and_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sample_valid = 1'b0;
   logic        inA = 1'b0, inB = 1'b0, inC = 1'b0, inD = 1'b0;
   logic        dutOut = 1'b0;
   logic        busy, done, pass, firstErrValid, timeout;
   logic [4:0]  errCount;
   logic [15:0] covered;
   logic [3:0]  firstErrVec;

   int testsRun    = 0;
   int testsFailed = 0;
   int cyc         = 0;
   int lastCyc     = 0;
   int startEdge   = 0;
   logic doneD     = 1'b0;

   typedef struct {
      logic [4:0]  err;
      logic [15:0] cov;
      logic [3:0]  fev;
      logic        fevV;
      logic        pass;
      logic        tmo;
      int          doneCyc;
   } expT;

   expT expQ[$];

   four_and_checker #(.MAX_SAMPLES(64), .TIMEOUT_CYCLES(200)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
      .inA(inA), .inB(inB), .inC(inC), .inD(inD), .dutOut(dutOut),
      .busy(busy), .done(done), .pass(pass), .errCount(errCount),
      .covered(covered), .firstErrVec(firstErrVec),
      .firstErrValid(firstErrValid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic checkAllZero(input string name);
      check({name, " busy"}, busy, 0);
      check({name, " done"}, done, 0);
      check({name, " pass"}, pass, 0);
      check({name, " errCount"}, errCount, 0);
      check({name, " covered"}, covered, 0);
      check({name, " firstErrVec"}, firstErrVec, 0);
      check({name, " firstErrValid"}, firstErrValid, 0);
      check({name, " timeout"}, timeout, 0);
   endtask

   task automatic sendSample(input logic [3:0] v, input logic out);
      @(negedge clk);
      {inA, inB, inC, inD} = v;
      dutOut       = out;
      sample_valid = 1'b1;
      lastCyc      = cyc + 1;
      @(posedge clk);
      #1 sample_valid = 1'b0;
   endtask

   task automatic pulseStart();
      @(negedge clk);
      start     = 1'b1;
      startEdge = cyc + 1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic pushExp(input logic [4:0] err, input logic [15:0] cov, input logic [3:0] fev,
                          input logic fevV, input logic ps, input logic tmo, input int dc);
      expT e;
      e.err = err; e.cov = cov; e.fev = fev; e.fevV = fevV;
      e.pass = ps; e.tmo = tmo; e.doneCyc = dc;
      expQ.push_back(e);
   endtask

   task automatic waitDone(input string name, input int maxCyc);
      int n = 0;
      @(negedge clk);
      while (!done && n < maxCyc) begin
         @(negedge clk);
         n++;
      end
      check({name, " doneReached"}, done, 1);
   endtask

   // Monitor: compare the oldest expected result whenever done rises.
   initial begin
      expT e;
      forever begin
         @(negedge clk);
         if (done && !doneD) begin
            if (expQ.size() == 0) begin
               check("unexpectedDone queueSize", expQ.size(), 1);
            end else begin
               e = expQ.pop_front();
               check("sb doneCycle", cyc, e.doneCyc);
               check("sb errCount", errCount, e.err);
               check("sb covered", covered, e.cov);
               check("sb firstErrVec", firstErrVec, e.fev);
               check("sb firstErrValid", firstErrValid, e.fevV);
               check("sb pass", pass, e.pass);
               check("sb timeout", timeout, e.tmo);
               check("sb busy", busy, 0);
            end
         end
         doneD = done;
      end
   end

   initial begin
      #200000;
      $display("FAIL globalTimeout: simulation time %0t exceeded limit", $time);
      $fatal(1, "bench time limit");
   end

   initial begin
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idleAfterReset busy", busy, 0);
      check("idleAfterReset done", done, 0);

      // A: all 16 vectors correct; a start pulse mid-run must be ignored.
      pulseStart();
      check("A busy", busy, 1);
      for (int i = 0; i < 8; i++) sendSample(4'(i), (i == 15));
      pulseStart();
      for (int i = 8; i < 16; i++) sendSample(4'(i), (i == 15));
      pushExp(5'd0, 16'hFFFF, 4'h0, 1'b0, 1'b1, 1'b0, lastCyc);
      waitDone("A", 4);
      sendSample(4'h5, 1'b1);
      sendSample(4'hF, 1'b0);
      @(negedge clk);
      check("A hold errCount", errCount, 0);
      check("A hold covered", covered, 16'hFFFF);
      check("A hold pass", pass, 1);
      check("A hold done", done, 1);

      // B: restart from DONE; wrong response at 4'hF.
      pulseStart();
      check("B cleared covered", covered, 0);
      check("B cleared pass", pass, 0);
      check("B busy", busy, 1);
      for (int i = 0; i < 16; i++) sendSample(4'(i), 1'b0);
      pushExp(5'd1, 16'hFFFF, 4'hF, 1'b1, 1'b0, 1'b0, lastCyc);
      waitDone("B", 4);

      // C: vector 0 repeated until the 64-sample budget ends the run.
      pulseStart();
      for (int i = 0; i < 64; i++) sendSample(4'h0, 1'b0);
      pushExp(5'd0, 16'h0001, 4'h0, 1'b0, 1'b0, 1'b0, lastCyc);
      waitDone("C", 4);

      // D: 40 mismatches saturate the count, then 24 correct samples fill the budget.
      pulseStart();
      for (int i = 0; i < 40; i++) sendSample(4'((i + 3) % 8), 1'b1);
      check("D midrun errCount", errCount, 31);
      for (int i = 0; i < 24; i++) sendSample(4'h0, 1'b0);
      pushExp(5'd31, 16'h00FF, 4'h3, 1'b1, 1'b0, 1'b0, lastCyc);
      waitDone("D", 4);

      // E: reset mid-run, stay idle, then a clean run.
      pulseStart();
      for (int i = 1; i <= 5; i++) sendSample(4'(i), 1'b0);
      check("E busy before reset", busy, 1);
      check("E covered before reset", covered, 16'h003E);
      @(negedge clk) rst_n = 1'b0;
      #1 checkAllZero("E asyncReset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("E idle busy", busy, 0);
      check("E idle done", done, 0);
      pulseStart();
      for (int i = 15; i >= 0; i--) sendSample(4'(i), (i == 15));
      pushExp(5'd0, 16'hFFFF, 4'h0, 1'b0, 1'b1, 1'b0, lastCyc);
      waitDone("E", 4);

      // T: start with no samples.
      pulseStart();
`ifdef FOUR_AND_CHK_TIMEOUT_EN
      pushExp(5'd0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b1, startEdge + 200);
      waitDone("T", 260);
      check("T timeout", timeout, 1);
      check("T pass", pass, 0);
`else
      repeat (250) @(negedge clk);
      check("T busy", busy, 1);
      check("T done", done, 0);
      check("T timeout", timeout, 0);
`endif

      repeat (2) @(negedge clk);
      check("queueEmpty", expQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
